// File: rtl/fetch_stage.sv
// fetch_stage: single-outstanding instruction fetch with branch redirect and a one-entry decode buffer.
// Define FETCH_PERF_EN to add the perf_fetch_cnt / perf_kill_cnt counters.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_inst,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc4
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_kill_cnt
`endif
);

    // state  | meaning
    // S_REQ  | no request outstanding; issue one when the buffer can take it
    // S_WAIT | one request outstanding; kill_q marks its response as stale
    typedef enum logic {
        S_REQ  = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic        kill_q, kill_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pc_plus4;

    logic        valid_q, valid_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] bpc_q, bpc_d;
    logic [31:0] bpc4_q, bpc4_d;

    logic        req_fire;
    logic        xfer;
    logic        rsp_in_wait;
    logic        rsp_accept;
    logic        rsp_discard;

    assign pc_plus4    = pc_q + 32'd4;
    assign xfer        = valid_q && if_ready;
    assign req_fire    = imem_req_valid && imem_req_ready;
    assign rsp_in_wait = (state_q == S_WAIT) && imem_rsp_valid;
    assign rsp_accept  = rsp_in_wait && !kill_q && !br_taken;
    assign rsp_discard = rsp_in_wait && (kill_q || br_taken);

    // Request only when the buffer will have room at the response; gated off while in reset.
    assign imem_req_valid = rst_n && (state_q == S_REQ) && (!valid_q || if_ready);
    assign imem_req_addr  = pc_q;

    assign if_valid = valid_q;
    assign if_inst  = inst_q;
    assign if_pc    = bpc_q;
    assign if_pc4   = bpc4_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_REQ;
            kill_q  <= 1'b0;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            kill_q  <= kill_d;
            pc_q    <= pc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        kill_d  = kill_q;
        case (state_q)
            S_REQ: begin
                if (req_fire) begin
                    state_d = S_WAIT;
                    kill_d  = br_taken;
                end
            end
            S_WAIT: begin
                if (imem_rsp_valid) begin
                    state_d = S_REQ;
                    kill_d  = 1'b0;
                end else if (br_taken) begin
                    kill_d = 1'b1;
                end
            end
            default: begin
                state_d = S_REQ;
                kill_d  = 1'b0;
            end
        endcase
    end

    always_comb begin
        pc_d = pc_q;
        if (br_taken) begin
            pc_d = br_target;
        end else if (rsp_accept) begin
            pc_d = pc_plus4;
        end
    end

    // Redirect beats reload, reload beats drain.
    always_comb begin
        valid_d = valid_q;
        inst_d  = inst_q;
        bpc_d   = bpc_q;
        bpc4_d  = bpc4_q;
        if (br_taken) begin
            valid_d = 1'b0;
        end else if (rsp_accept) begin
            valid_d = 1'b1;
            inst_d  = imem_rsp_data;
            bpc_d   = pc_q;
            bpc4_d  = pc_plus4;
        end else if (xfer) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            inst_q  <= 32'd0;
            bpc_q   <= 32'd0;
            bpc4_q  <= 32'd0;
        end else begin
            valid_q <= valid_d;
            inst_q  <= inst_d;
            bpc_q   <= bpc_d;
            bpc4_q  <= bpc4_d;
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch_cnt <= 32'd0;
            perf_kill_cnt  <= 32'd0;
        end else begin
            if (xfer) begin
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            end
            if (rsp_discard) begin
                perf_kill_cnt <= perf_kill_cnt + 32'd1;
            end
        end
    end
`else
    logic unused_discard;
    assign unused_discard = rsp_discard;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: randomized fetch traffic with a memory model and an expected-PC-stream scoreboard.
module tb_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        br_taken;
    logic [31:0] br_target;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic [31:0] if_pc4;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_kill_cnt;
`endif

    fetch_stage #(.RESET_PC(RST_PC)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .br_taken       (br_taken),
        .br_target      (br_target),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_inst        (if_inst),
        .if_pc          (if_pc),
        .if_pc4         (if_pc4)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_kill_cnt  (perf_kill_cnt)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Expected PC of the next instruction handed to decode.
    logic [31:0] exp_q[$];

    // Memory model knobs and visible state.
    int  ready_pct = 100;
    int  lat_min   = 1;
    int  lat_max   = 1;
    int  lat_force = 0;
    bit  mem_hold  = 1'b0;
    bit  spur_en   = 1'b0;
    bit  mem_pend  = 1'b0;
    int  mem_cnt   = 0;
    bit  rsp_real  = 1'b0;
    int  exp_kills = 0;
    int  n_xfer    = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC3A5_96E1;
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting, got no event expected event", name);
    endtask

    // Instruction memory: one response per accepted request after a random latency,
    // optional spurious responses when nothing is outstanding.
    initial begin
        bit          hs, br, rv, orphan, rsp_orphan;
        logic [31:0] haddr, paddr;
        int          tag, epoch, e_new;
        orphan = 0; rsp_orphan = 0; tag = 0; epoch = 0; paddr = 0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'd0;
        forever begin
            @(negedge clk);
            hs    = imem_req_valid && imem_req_ready;
            haddr = imem_req_addr;
            br    = br_taken;
            rv    = rsp_real && imem_rsp_valid;
            if (!rst_n) begin
                if (mem_pend) orphan = 1'b1;
                exp_kills = 0;
            end
            e_new = epoch + (br ? 1 : 0);
            // A genuine response is stale if a redirect happened at or after its request.
            if (rv && !rsp_orphan && rst_n && tag != e_new) exp_kills++;
            if (hs) begin
                check1("one_outstanding", mem_pend, 1'b0);
                mem_pend = 1'b1;
                orphan   = 1'b0;
                tag      = epoch;
                paddr    = haddr;
                mem_cnt  = (lat_force != 0) ? lat_force : $urandom_range(lat_max, lat_min);
            end
            epoch = e_new;
            @(posedge clk);
            #1;
            imem_rsp_valid = 1'b0;
            rsp_real       = 1'b0;
            imem_rsp_data  = $urandom;
            if (mem_pend) begin
                mem_cnt--;
                if (mem_cnt == 0) begin
                    imem_rsp_valid = 1'b1;
                    imem_rsp_data  = mem_word(paddr);
                    rsp_real       = 1'b1;
                    rsp_orphan     = orphan;
                    mem_pend       = 1'b0;
                end
            end else if (spur_en && $urandom_range(9, 0) == 0) begin
                imem_rsp_valid = 1'b1;
            end
            imem_req_ready = !mem_hold && ($urandom_range(99, 0) < ready_pct);
        end
    end

    // Monitor: pops the expected stream on every decode transfer and checks protocol rules.
    initial begin
        bit          prev_br, tgt_chk, stall_prev;
        logic [31:0] prev_tgt, tgt, s_inst, s_pc, e;
        prev_br = 0; tgt_chk = 0; stall_prev = 0;
        prev_tgt = 0; tgt = 0; s_inst = 0; s_pc = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_br    = 1'b0;
                stall_prev = 1'b0;
                tgt_chk    = 1'b1;
                tgt        = RST_PC;
                n_xfer     = 0;
            end else begin
                if (prev_br) begin
                    check1("inv_after_br", if_valid, 1'b0);
                    tgt_chk = 1'b1;
                    tgt     = prev_tgt;
                end
                if (imem_req_valid && imem_req_ready && tgt_chk && !br_taken) begin
                    check32("first_req_addr", imem_req_addr, tgt);
                    tgt_chk = 1'b0;
                end
                if (stall_prev) begin
                    check1("stall_valid", if_valid, 1'b1);
                    check32("stall_inst", if_inst, s_inst);
                    check32("stall_pc", if_pc, s_pc);
                end
                if (if_valid && !if_ready) check1("no_req_while_full", imem_req_valid, 1'b0);
                if (if_valid && if_ready) begin
                    n_xfer++;
                    if (exp_q.size() == 0) begin
                        timeout_fail("unexpected_transfer");
                    end else begin
                        e = exp_q.pop_front();
                        check32("if_pc", if_pc, e);
                        check32("if_inst", if_inst, mem_word(e));
                        check32("if_pc4", if_pc4, e + 32'd4);
                        exp_q.push_back(e + 32'd4);
                    end
                end
                stall_prev = if_valid && !if_ready && !br_taken;
                s_inst     = if_inst;
                s_pc       = if_pc;
                prev_br    = br_taken;
                prev_tgt   = br_target;
            end
        end
    end

    task automatic do_branch(input logic [31:0] tgt);
        br_taken  = 1'b1;
        br_target = tgt;
        if_ready  = 1'b0;
        exp_q.delete();
        exp_q.push_back(tgt);
    endtask

    task automatic run_cycles(input int n, input int br_pct, input int ifr_pct);
        logic [31:0] t;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            br_taken = 1'b0;
            if (br_pct > 0 && $urandom_range(99, 0) < br_pct) begin
                t = $urandom & 32'hFFFF_FFFC;
                if ($urandom_range(3, 0) == 0) t = 32'hFFFF_FFF8 | ($urandom & 32'h4);
                do_branch(t);
            end else begin
                br_target = $urandom;
                if_ready  = ($urandom_range(99, 0) < ifr_pct);
            end
        end
    endtask

    task automatic check_perf();
`ifdef FETCH_PERF_EN
        @(posedge clk);
        #3;
        check32("perf_fetch_cnt", perf_fetch_cnt, n_xfer);
        check32("perf_kill_cnt", perf_kill_cnt, exp_kills);
`endif
    endtask

    initial begin
        bit found;
        rst_n     = 1'b0;
        br_taken  = 1'b0;
        br_target = 32'd0;
        if_ready  = 1'b1;
        exp_q.delete();
        exp_q.push_back(RST_PC);

        repeat (3) @(negedge clk);
        check1("rst_if_valid", if_valid, 1'b0);
        check1("rst_req_valid", imem_req_valid, 1'b0);
        check32("rst_if_inst", if_inst, 32'd0);
        check32("rst_if_pc", if_pc, 32'd0);
        check32("rst_if_pc4", if_pc4, 32'd0);
        check32("rst_req_addr", imem_req_addr, RST_PC);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        check1("req_valid_after_release", imem_req_valid, 1'b1);

        // Streaming: always ready, 1-cycle memory, decode always ready.
        run_cycles(30, 0, 100);
        check_perf();

        // Decode stall of 5 cycles with a full buffer.
        found = 0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(posedge clk);
            #1;
            if (if_valid) found = 1;
        end
        if (!found) timeout_fail("wait_if_valid");
        if_ready = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        run_cycles(10, 0, 100);

        // Redirect to 0x2000 while waiting on a 3-cycle response.
        lat_force = 3;
        found = 0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(posedge clk);
            #2;
            if (mem_pend && mem_cnt == 2) found = 1;
        end
        if (!found) timeout_fail("wait_pending");
        do_branch(32'h0000_2000);
        run_cycles(20, 0, 100);
        lat_force = 0;
        check_perf();

        // Fetch across the 32-bit wrap.
        @(posedge clk);
        #1;
        do_branch(32'hFFFF_FFFC);
        run_cycles(20, 0, 100);

        // Redirect coincident with a genuine response.
        lat_min = 2;
        lat_max = 2;
        found = 0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(posedge clk);
            #2;
            if (rsp_real) found = 1;
        end
        if (!found) timeout_fail("wait_response");
        do_branch(32'h0000_4440);
        run_cycles(20, 0, 100);
        check_perf();

        // Random traffic.
        ready_pct = 70;
        lat_min   = 1;
        lat_max   = 4;
        spur_en   = 1'b1;
        run_cycles(2500, 6, 60);
        check_perf();

        // Reset while a request is outstanding; its late response must be ignored.
        spur_en   = 1'b0;
        ready_pct = 100;
        lat_force = 3;
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(posedge clk);
            #2;
            br_taken = 1'b0;
            if_ready = 1'b1;
            if (mem_pend && mem_cnt == 2) found = 1;
        end
        if (!found) timeout_fail("wait_pending_rst");
        mem_hold = 1'b1;
        rst_n    = 1'b0;
        exp_q.delete();
        exp_q.push_back(RST_PC);
        #1;
        check1("async_rst_if_valid", if_valid, 1'b0);
        check1("async_rst_req_valid", imem_req_valid, 1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        found = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check1("orphan_if_valid", if_valid, 1'b0);
            if (!mem_pend) found = 1;
        end
        if (!found) timeout_fail("orphan_response");
        mem_hold  = 1'b0;
        lat_force = 0;
        run_cycles(30, 0, 100);
        check_perf();
        run_cycles(300, 5, 70);
        check_perf();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
